// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache -- direct-mapped, read-only instruction cache
//
// Answers the fetch unit's query/data handshake. A hit returns the stored
// word one cycle after the query. A miss issues a single word read to the
// memory controller, fills the line when the word arrives, and returns it on
// the following cycle. Each line holds one 32-bit word, its tag, and a parity
// bit over {tag, word}. A line whose parity does not check is treated as a
// miss, so a corrupted line is refetched instead of being handed to fetch.
//
// Ports
//   clk_in           clock, rising edge
//   rst_in           asynchronous active-low reset
//   rdy_in           global ready; when low every register and the arrays hold
//   icache_query_en  single-cycle query pulse from the fetch unit
//   icache_query_pc  query address (bits [1:0] ignored)
//   icache_data_en   single-cycle pulse: icache_data is valid
//   icache_data      instruction word for the accepted query
//   flush_in         misprediction flush; abandons the pending response
//   mem_req_en       word read request, held high until the response arrives
//   mem_req_addr     word-aligned request address
//   mem_resp_en      single-cycle pulse: mem_resp_data is valid
//   mem_resp_data    word returned by the memory controller
// ---------------------------------------------------------------------------
module icache #(
  parameter int INDEX_WIDTH = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  icache_query_en,
  input  logic [ADDR_WIDTH-1:0] icache_query_pc,
  output logic                  icache_data_en,
  output logic [31:0]           icache_data,
  input  logic                  flush_in,
  output logic                  mem_req_en,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_en,
  input  logic [31:0]           mem_resp_data
);

  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_t;

  // Even parity over the stored tag and word of one line.
  function automatic logic line_parity(input logic [TAG_WIDTH-1:0] tag,
                                       input logic [31:0]          word);
    return ^{tag, word};
  endfunction

  // Line storage. Contents are only trusted where valid_r is set.
  logic [TAG_WIDTH-1:0] tag_mem_r  [LINES];
  logic [31:0]          data_mem_r [LINES];
  logic                 par_mem_r  [LINES];
  logic [LINES-1:0]     valid_r;

  state_t               state_r;
  logic                 aborted_r;
  logic                 data_en_r;
  // Word address (pc[ADDR_WIDTH-1:2]) of the outstanding miss.
  logic [ADDR_WIDTH-3:0] miss_pc_r;

  logic [INDEX_WIDTH-1:0] q_index_s;
  logic [TAG_WIDTH-1:0]   q_tag_s;
  logic [TAG_WIDTH-1:0]   line_tag_s;
  logic [31:0]            line_word_s;
  logic                   line_par_ok_s;
  logic                   hit_s;
  logic                   fill_s;
  logic [INDEX_WIDTH-1:0] miss_index_s;
  logic [TAG_WIDTH-1:0]   miss_tag_s;
  logic                   unused_pc_bits_s;

  assign unused_pc_bits_s = ^icache_query_pc[1:0];

  // Lookup of the queried line and decode of the fill condition.
  always_comb begin
    q_index_s     = icache_query_pc[INDEX_WIDTH+1:2];
    q_tag_s       = icache_query_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    line_tag_s    = tag_mem_r[q_index_s];
    line_word_s   = data_mem_r[q_index_s];
    miss_index_s  = miss_pc_r[INDEX_WIDTH-1:0];
    miss_tag_s    = miss_pc_r[ADDR_WIDTH-3:INDEX_WIDTH];
    line_par_ok_s = (line_parity(line_tag_s, line_word_s) == par_mem_r[q_index_s]);
    hit_s         = 1'b0;
    fill_s        = 1'b0;
    if (valid_r[q_index_s] && (line_tag_s == q_tag_s) && line_par_ok_s) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    if (rdy_in && (state_r == MISS) && mem_resp_en) begin
      fill_s = 1'b1;
    end else begin
      fill_s = 1'b0;
    end
  end

  // A flush in the cycle a response is presented withdraws it; with rdy_in
  // low the flush input is ignored and the pulse simply holds.
  assign icache_data_en = data_en_r & ~(rdy_in & flush_in);

  // Tag/data/parity array write on fill; arrays carry no reset.
  always_ff @(posedge clk_in) begin
    if (fill_s) begin
      tag_mem_r[miss_index_s]  <= miss_tag_s;
      data_mem_r[miss_index_s] <= mem_resp_data;
      par_mem_r[miss_index_s]  <= line_parity(miss_tag_s, mem_resp_data);
    end
  end

  // Control FSM with registered response and memory-request outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r      <= IDLE;
      aborted_r    <= 1'b0;
      data_en_r    <= 1'b0;
      icache_data  <= 32'd0;
      mem_req_en   <= 1'b0;
      mem_req_addr <= {ADDR_WIDTH{1'b0}};
      miss_pc_r    <= {(ADDR_WIDTH-2){1'b0}};
      valid_r      <= {LINES{1'b0}};
    end else if (rdy_in) begin
      case (state_r)
        IDLE: begin
          data_en_r <= 1'b0;
          // A query arriving together with a flush is dropped outright.
          if (icache_query_en && !flush_in) begin
            if (hit_s) begin
              data_en_r   <= 1'b1;
              icache_data <= line_word_s;
            end else begin
              miss_pc_r    <= icache_query_pc[ADDR_WIDTH-1:2];
              mem_req_en   <= 1'b1;
              mem_req_addr <= {icache_query_pc[ADDR_WIDTH-1:2], 2'b00};
              aborted_r    <= 1'b0;
              state_r      <= MISS;
            end
          end
        end
        MISS: begin
          data_en_r <= 1'b0;
          if (mem_resp_en) begin
            // The fill always completes; a flush only suppresses the reply.
            mem_req_en             <= 1'b0;
            valid_r[miss_index_s]  <= 1'b1;
            icache_data            <= mem_resp_data;
            data_en_r              <= ~(aborted_r | flush_in);
            aborted_r              <= aborted_r | flush_in;
            state_r                <= RESP;
          end else if (flush_in) begin
            aborted_r <= 1'b1;
          end
        end
        RESP: begin
          data_en_r <= 1'b0;
          aborted_r <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          data_en_r  <= 1'b0;
          aborted_r  <= 1'b0;
          mem_req_en <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
    // rdy_in low: every register keeps its value.
  end

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache -- directed, scoreboard-checked bench for icache.
// Stimulus pushes the expected word of every response it expects into exp_q;
// the monitor pops and compares whenever icache_data_en is seen high.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        icache_query_en = 1'b0;
  logic [31:0] icache_query_pc = 32'd0;
  logic        icache_data_en;
  logic [31:0] icache_data;
  logic        flush_in = 1'b0;
  logic        mem_req_en;
  logic [31:0] mem_req_addr;
  logic        mem_resp_en = 1'b0;
  logic [31:0] mem_resp_data = 32'd0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  icache #(.INDEX_WIDTH(4), .ADDR_WIDTH(32)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .icache_query_en (icache_query_en),
    .icache_query_pc (icache_query_pc),
    .icache_data_en  (icache_data_en),
    .icache_data     (icache_data),
    .flush_in        (flush_in),
    .mem_req_en      (mem_req_en),
    .mem_req_addr    (mem_req_addr),
    .mem_resp_en     (mem_resp_en),
    .mem_resp_data   (mem_resp_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_in && icache_data_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_response: got data 0x%08h, expected no response", icache_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (icache_data !== mon_exp) begin
          n_fail++;
          $display("FAIL response_data: got 0x%08h, expected 0x%08h", icache_data, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic query(input logic [31:0] pc, input logic with_flush);
    icache_query_en = 1'b1;
    icache_query_pc = pc;
    flush_in        = with_flush;
    step();
    icache_query_en = 1'b0;
    flush_in        = 1'b0;
  endtask

  // Memory serves an outstanding miss after 'delay' request cycles.
  task automatic serve(input logic [31:0] addr, input logic [31:0] data,
                       input int delay, input logic pulse);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_in);
      check("miss_req_en", {31'd0, mem_req_en}, 32'd1);
      check("miss_req_addr", mem_req_addr, addr);
      check("miss_no_data_en", {31'd0, icache_data_en}, 32'd0);
      step();
    end
    mem_resp_en   = 1'b1;
    mem_resp_data = data;
    if (pulse) exp_q.push_back(data);
    step();
    mem_resp_en = 1'b0;
    @(negedge clk_in);
    check("req_dropped_after_resp", {31'd0, mem_req_en}, 32'd0);
    check("resp_pulse_timing", {31'd0, icache_data_en}, {31'd0, pulse});
    step();
    @(negedge clk_in);
    check("resp_pulse_single", {31'd0, icache_data_en}, 32'd0);
    step();
  endtask

  task automatic hit(input logic [31:0] pc, input logic [31:0] data);
    exp_q.push_back(data);
    query(pc, 1'b0);
    @(negedge clk_in);
    check("hit_data_en", {31'd0, icache_data_en}, 32'd1);
    check("hit_no_mem_req", {31'd0, mem_req_en}, 32'd0);
    step();
    @(negedge clk_in);
    check("hit_pulse_single", {31'd0, icache_data_en}, 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2 rst_in = 1'b0;
    #2;
    check("reset_data_en", {31'd0, icache_data_en}, 32'd0);
    check("reset_data", icache_data, 32'd0);
    check("reset_req_en", {31'd0, mem_req_en}, 32'd0);
    check("reset_req_addr", mem_req_addr, 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    step();

    // 1. Cold miss
    query(32'h0000_0010, 1'b0);
    serve(32'h0000_0010, 32'h0000_0513, 3, 1'b1);

    // 2. Hit
    hit(32'h0000_0010, 32'h0000_0513);

    // 3. Conflict eviction on index 4, then 0x50 is evicted in turn
    query(32'h0000_0050, 1'b0);
    serve(32'h0000_0050, 32'hAAAA_0050, 2, 1'b1);
    query(32'h0000_0010, 1'b0);
    serve(32'h0000_0010, 32'h0000_0513, 2, 1'b1);
    query(32'h0000_0050, 1'b0);
    serve(32'h0000_0050, 32'hAAAA_0050, 1, 1'b1);

    // 4. Flush during miss: fill happens, no response
    query(32'h0000_0020, 1'b0);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    serve(32'h0000_0020, 32'h1234_5678, 2, 1'b0);
    hit(32'h0000_0020, 32'h1234_5678);

    // Query together with flush in IDLE is dropped (line 0x20 would hit)
    query(32'h0000_0020, 1'b1);
    @(negedge clk_in);
    check("flushed_query_no_resp", {31'd0, icache_data_en}, 32'd0);
    check("flushed_query_no_req", {31'd0, mem_req_en}, 32'd0);
    step();

    // Simultaneous mem_resp_en and flush_in: fill, no response
    query(32'h0000_0024, 1'b0);
    flush_in = 1'b1;
    serve(32'h0000_0024, 32'h0000_0024, 0, 1'b0);
    flush_in = 1'b0;
    hit(32'h0000_0024, 32'h0000_0024);

    // 5. rdy_in stall while in MISS
    query(32'h0000_0030, 1'b0);
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_resp_en   = (i % 2 == 0);
      mem_resp_data = 32'hDEAD_BEEF;
      @(negedge clk_in);
      check("stall_req_held", {31'd0, mem_req_en}, 32'd1);
      check("stall_no_data_en", {31'd0, icache_data_en}, 32'd0);
      step();
    end
    mem_resp_en = 1'b0;
    rdy_in      = 1'b1;
    serve(32'h0000_0030, 32'h0BAD_F00D, 1, 1'b1);
    hit(32'h0000_0030, 32'h0BAD_F00D);

    // 6. Async reset mid-miss
    query(32'h0000_0040, 1'b0);
    @(negedge clk_in);
    check("pre_reset_req_en", {31'd0, mem_req_en}, 32'd1);
    rst_in = 1'b0;
    #1;
    check("async_reset_req_en", {31'd0, mem_req_en}, 32'd0);
    check("async_reset_req_addr", mem_req_addr, 32'd0);
    check("async_reset_data", icache_data, 32'd0);
    check("async_reset_data_en", {31'd0, icache_data_en}, 32'd0);
    step();
    rst_in = 1'b1;
    step();
    // Late memory response lands in IDLE and must be ignored
    mem_resp_en   = 1'b1;
    mem_resp_data = 32'hFFFF_FFFF;
    step();
    mem_resp_en = 1'b0;
    @(negedge clk_in);
    check("late_resp_ignored", {31'd0, icache_data_en}, 32'd0);
    check("late_resp_no_req", {31'd0, mem_req_en}, 32'd0);
    step();
    // Previously cached 0x10 must now miss
    query(32'h0000_0010, 1'b0);
    serve(32'h0000_0010, 32'h0000_0513, 2, 1'b1);
    hit(32'h0000_0010, 32'h0000_0513);

    repeat (2) step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
